// File: rtl/dm_bus_ctrl_pkg.sv
// Shared definitions for the data-memory bus controller: DMType encodings
// (same values as the core's control decode) and the controller state encoding.
package dm_bus_ctrl_pkg;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RDW  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Unknown encodings size like a word, so they need a word-aligned address.
  function automatic logic is_misaligned(input logic [2:0] dmtype, input logic [1:0] a);
    case (dmtype)
      DM_B, DM_BU: return 1'b0;
      DM_H, DM_HU: return a[0];
      default:     return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering between the core's right-justified data and the word bus.
// LOAD=0: places store data and builds byte enables; LOAD=1: extracts and extends.
module dm_lane
  import dm_bus_ctrl_pkg::*;
#(
  parameter bit LOAD = 1'b0
) (
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dmtype,
  input  logic [31:0] data_in,
  output logic [3:0]  be,
  output logic [31:0] data_out
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = data_in[{addr_lo, 3'b000} +: 8];
    half_v   = data_in[{addr_lo[1], 4'b0000} +: 16];
    be       = 4'b1111;
    data_out = data_in;
    case (dmtype)
      DM_B, DM_BU: begin
        be = 4'b0001 << addr_lo;
        if (LOAD) data_out = (dmtype == DM_B) ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
        else      data_out = {4{data_in[7:0]}};
      end
      DM_H, DM_HU: begin
        // Half accesses ignore addr[0]: the lane is chosen by addr[1] alone.
        be = 4'b0011 << {addr_lo[1], 1'b0};
        if (LOAD) data_out = (dmtype == DM_H) ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
        else      data_out = {2{data_in[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        data_out = data_in;
      end
    endcase
  end

endmodule

// File: rtl/dm_bus_ctrl.sv
// MEM-stage data-memory controller: byte-granular core requests to a word bus,
// stalling the pipeline until done. Optional misaligned trap: DM_MISALIGN_TRAP_EN.
module dm_bus_ctrl
  import dm_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_dmtype,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic [1:0]  fsm_state
);

  // Bus handshake: bus_req is valid, bus_gnt is ready; a request transfers on a
  // rising edge with both high, and bus_we/addr/be/wdata stay frozen while bus_req
  // waits. Read data transfers on any edge with bus_rvalid high in REQ (with gnt) or RDW.

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        req_alo;
  logic [2:0]        req_dmtype;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;
  logic [3:0]        unused_ld_be;
  logic              req_any;
  logic              tmo;
  logic              capture;
  logic              load_rd;
  logic              zero_rd;
  logic              set_err;
`ifdef DM_MISALIGN_TRAP_EN
  logic              set_mis;
`endif

  dm_lane #(.LOAD(1'b0)) u_store (
    .addr_lo  (cpu_addr[1:0]),
    .dmtype   (cpu_dmtype),
    .data_in  (cpu_wdata),
    .be       (st_be),
    .data_out (st_data)
  );

  dm_lane #(.LOAD(1'b1)) u_load (
    .addr_lo  (req_alo),
    .dmtype   (req_dmtype),
    .data_in  (bus_rdata),
    .be       (unused_ld_be),
    .data_out (ld_data)
  );

  assign req_any   = cpu_re | cpu_we;
  assign tmo       = (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign cpu_stall = ((state == IDLE) & req_any) | (state == REQ) | (state == RDW);
  assign bus_req   = (state == REQ);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    load_rd = 1'b0;
    zero_rd = 1'b0;
    set_err = 1'b0;
`ifdef DM_MISALIGN_TRAP_EN
    set_mis = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_any) begin
`ifdef DM_MISALIGN_TRAP_EN
          if (is_misaligned(cpu_dmtype, cpu_addr[1:0])) begin
            set_mis = 1'b1;
            zero_rd = ~cpu_we;
            state_n = DONE;
          end else begin
            capture = 1'b1;
            state_n = REQ;
          end
`else
          capture = 1'b1;
          state_n = REQ;
`endif
        end
      end
      REQ: begin
        if (bus_gnt) begin
          if (bus_we) begin
            state_n = DONE;
          end else if (bus_rvalid) begin
            load_rd = 1'b1;
            state_n = DONE;
          end else begin
            state_n = RDW;
          end
        end else if (tmo) begin
          set_err = 1'b1;
          zero_rd = ~bus_we;
          state_n = DONE;
        end
      end
      RDW: begin
        if (bus_rvalid) begin
          load_rd = 1'b1;
          state_n = DONE;
        end else if (tmo) begin
          set_err = 1'b1;
          zero_rd = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      req_alo    <= '0;
      req_dmtype <= '0;
      cpu_rdata  <= '0;
      bus_err    <= 1'b0;
      cnt        <= '0;
    end else begin
      if (capture) begin
        bus_we     <= cpu_we;
        bus_addr   <= {cpu_addr[31:2], 2'b00};
        bus_be     <= st_be;
        bus_wdata  <= st_data;
        req_alo    <= cpu_addr[1:0];
        req_dmtype <= cpu_dmtype;
      end
      if (load_rd)      cpu_rdata <= ld_data;
      else if (zero_rd) cpu_rdata <= '0;
      if (set_err) bus_err <= 1'b1;
      if (capture)                            cnt <= '0;
      else if (state == REQ || state == RDW)  cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef DM_MISALIGN_TRAP_EN
  // Registered so the pulse lines up with the single DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cpu_misalign <= 1'b0;
    else      cpu_misalign <= set_mis;
  end
`else
  assign cpu_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Directed bench for dm_bus_ctrl: store/load lane formatting, latency, timeout,
// reset mid-transaction and misaligned handling (both DM_MISALIGN_TRAP_EN builds).
module tb_dm_bus_ctrl;
  import dm_bus_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_re = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [2:0]  cpu_dmtype = '0;
  logic        cpu_stall, cpu_misalign;
  logic [31:0] cpu_rdata;
  logic        bus_req, bus_we, bus_err;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [1:0]  fsm_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];
  logic [32:0] hs_exp;
  logic [31:0] snap_addr = '0, snap_wdata = '0;
  logic [3:0]  snap_be = '0;
  logic        snap_we = 1'b0;
  int          stalls;

  always #5 clk = ~clk;

  dm_bus_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_re       (cpu_re),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_dmtype   (cpu_dmtype),
    .cpu_stall    (cpu_stall),
    .cpu_rdata    (cpu_rdata),
    .cpu_misalign (cpu_misalign),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_gnt      (bus_gnt),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata),
    .bus_err      (bus_err),
    .fsm_state    (fsm_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted bus request must match the next expected {we, addr}.
  always @(negedge clk) begin
    #2;
    if (rst && bus_req && bus_gnt) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL bus_hs: observed unexpected request %0h expected none", {bus_we, bus_addr});
      end else begin
        hs_exp = exp_q.pop_front();
        check("bus_hs", {31'h0, bus_we, bus_addr}, {31'h0, hs_exp});
      end
    end
  end

  // One core access with a bus that grants after gnt_dly request cycles (-1: never)
  // and returns read data rv_dly cycles after the grant. Returns in the DONE cycle.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] dt, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, output int n_stall);
    int  req_cyc = 0;
    int  post    = 0;
    bit  granted = 1'b0;
    bit  done    = 1'b0;
    n_stall = 0;
    if (gnt_dly >= 0) exp_q.push_back({we, addr[31:2], 2'b00});
    @(negedge clk);
    cpu_we = we; cpu_re = ~we; cpu_addr = addr; cpu_wdata = wdata; cpu_dmtype = dt;
    for (int c = 0; c < 2000; c++) begin
      bus_gnt = 1'b0;
      bus_rvalid = 1'b0;
      if (bus_req && !granted) begin
        if (req_cyc == gnt_dly) begin
          bus_gnt = 1'b1;
          granted = 1'b1;
          snap_addr = bus_addr; snap_be = bus_be; snap_wdata = bus_wdata; snap_we = bus_we;
          if (!we && rv_dly == 0) begin bus_rvalid = 1'b1; bus_rdata = rdata; end
        end
        req_cyc++;
      end else if (granted && !we) begin
        post++;
        if (post == rv_dly) begin bus_rvalid = 1'b1; bus_rdata = rdata; end
      end
      #1;
      if (!cpu_stall) begin done = 1'b1; break; end
      n_stall++;
      @(negedge clk);
    end
    cpu_we = 1'b0;
    cpu_re = 1'b0;
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
    if (!done) n_stall = -1;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_state", fsm_state, IDLE);
    check("rst_stall", cpu_stall, 0);
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_be", bus_be, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_err", bus_err, 0);
    check("rst_mis", cpu_misalign, 0);
    @(negedge clk);
    rst = 1'b1;

    // sb 0xA5 at 0x103, grant on the second request cycle
    access(1'b1, 32'h103, 32'h0000_00A5, DM_B, 1, 0, 32'h0, stalls);
    check("sb_stalls", stalls, 3);
    check("sb_addr", snap_addr, 32'h100);
    check("sb_be", snap_be, 4'b1000);
    check("sb_wdata", snap_wdata, 32'hA5A5_A5A5);
    check("sb_we", snap_we, 1);
    check("sb_done", fsm_state, DONE);
    check("sb_rdata_kept", cpu_rdata, 0);

    // Sub-word loads from the word 0x8001_F0FF at 0x200
    access(1'b0, 32'h200, 32'h0, DM_B, 0, 1, 32'h8001_F0FF, stalls);
    check("lb_stalls", stalls, 3);
    check("lb_be", snap_be, 4'b0001);
    check("lb_rdata", cpu_rdata, 32'hFFFF_FFFF);
    access(1'b0, 32'h201, 32'h0, DM_BU, 2, 3, 32'h8001_F0FF, stalls);
    check("lbu_stalls", stalls, 7);
    check("lbu_rdata", cpu_rdata, 32'h0000_00F0);
    access(1'b0, 32'h202, 32'h0, DM_H, 0, 0, 32'h8001_F0FF, stalls);
    check("lh_stalls", stalls, 2);
    check("lh_rdata", cpu_rdata, 32'hFFFF_8001);
    check("lh_done", fsm_state, DONE);
    access(1'b0, 32'h202, 32'h0, DM_HU, 1, 0, 32'h8001_F0FF, stalls);
    check("lhu_stalls", stalls, 3);
    check("lhu_be", snap_be, 4'b1100);
    check("lhu_rdata", cpu_rdata, 32'h0000_8001);

    // Back-to-back lw then sw, each issued exactly once
    access(1'b0, 32'h204, 32'h0, DM_W, 0, 0, 32'h1234_5678, stalls);
    check("lw_stalls", stalls, 2);
    check("lw_rdata", cpu_rdata, 32'h1234_5678);
    access(1'b1, 32'h208, 32'hCAFE_F00D, DM_W, 0, 0, 32'h0, stalls);
    check("sw_stalls", stalls, 2);
    check("sw_be", snap_be, 4'b1111);
    check("sw_wdata", snap_wdata, 32'hCAFE_F00D);
    check("sw_rdata_kept", cpu_rdata, 32'h1234_5678);

    // sh 0xBEEF at 0x106
    access(1'b1, 32'h106, 32'h0000_BEEF, DM_H, 0, 0, 32'h0, stalls);
    check("sh_addr", snap_addr, 32'h104);
    check("sh_be", snap_be, 4'b1100);
    check("sh_wdata", snap_wdata, 32'hBEEF_BEEF);

    // Misaligned lw at 0x102
`ifdef DM_MISALIGN_TRAP_EN
    access(1'b0, 32'h102, 32'h0, DM_W, -1, 0, 32'h0BAD_F00D, stalls);
    check("mis_stalls", stalls, 1);
    check("mis_pulse", cpu_misalign, 1);
    check("mis_rdata", cpu_rdata, 0);
    check("mis_req", bus_req, 0);
`else
    access(1'b0, 32'h102, 32'h0, DM_W, 0, 0, 32'h0BAD_F00D, stalls);
    check("mis_stalls", stalls, 2);
    check("mis_addr", snap_addr, 32'h100);
    check("mis_be", snap_be, 4'b1111);
    check("mis_pulse", cpu_misalign, 0);
    check("mis_rdata", cpu_rdata, 32'h0BAD_F00D);
`endif

    // Timeout: grant never arrives
    access(1'b0, 32'h400, 32'h0, DM_W, -1, 0, 32'h0, stalls);
    check("tmo_stalls", stalls, 1024);
    check("tmo_err", bus_err, 1);
    check("tmo_req", bus_req, 0);
    check("tmo_rdata", cpu_rdata, 0);
    access(1'b0, 32'h404, 32'h0, DM_W, 0, 0, 32'h55AA_55AA, stalls);
    check("err_sticky", bus_err, 1);
    check("post_tmo_rdata", cpu_rdata, 32'h55AA_55AA);

    // Reset while waiting for read data
    @(negedge clk);
    cpu_re = 1'b1; cpu_addr = 32'h300; cpu_dmtype = DM_W;
    exp_q.push_back({1'b0, 32'h300});
    @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    check("rdw_state", fsm_state, RDW);
    rst = 1'b0;
    cpu_re = 1'b0;
    #1;
    check("arst_state", fsm_state, IDLE);
    check("arst_req", bus_req, 0);
    check("arst_rdata", cpu_rdata, 0);
    check("arst_err", bus_err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    check("late_rv_rdata", cpu_rdata, 0);
    check("late_rv_state", fsm_state, IDLE);

    @(negedge clk);
    #3;
    check("hs_all_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_bus_ctrl.md
Name: dm_bus_ctrl

Overview:
- Data-memory access controller directly downstream of the pipelined core's MEM stage.
- Takes the core's byte-granular load/store request (address, store data, DMType, read/write strobes) and converts it to a word-wide, variable-latency memory bus with byte enables.
- Freezes the pipeline with cpu_stall until the bus transaction completes, then returns load data right-justified and extended per DMType.

Parameters:
- TIMEOUT_CYC, 1023: bus cycles to wait for bus_gnt or bus_rvalid before aborting the access with bus_err.
- CNT_W, 10: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_re  in  1  load request from MEM stage.
- cpu_we  in  1  store request from MEM stage; cpu_re and cpu_we both high is treated as a store.
- cpu_addr  in  32  byte address (ALU result).
- cpu_wdata  in  32  store data, right-justified.
- cpu_dmtype  in  3  access size/sign: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
- cpu_stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
- cpu_rdata  out  32  load result, extended per DMType.
- cpu_misalign  out  1  misaligned-access pulse (feature only).
- bus_req  out  1  request valid.
- bus_we  out  1  write request.
- bus_addr  out  32  word address, bits [1:0] = 00.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-placed store data.
- bus_gnt  in  1  request accepted.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset: state IDLE. bus_req, bus_we, bus_be, bus_addr, bus_wdata, cpu_rdata, bus_err, cpu_misalign and the counter all go to 0.
- cpu_stall = (state==IDLE & (cpu_re|cpu_we)) | state==REQ | state==RDW. It is combinational and is 0 in DONE.
- IDLE: on cpu_re|cpu_we, register the lane-formatted request (addr, be, wdata, we, dmtype, addr[1:0]), clear the counter and go to REQ.
- REQ: bus_req=1, with outputs held stable until bus_gnt.
  - On gnt with write, go to DONE.
  - On gnt with read, go to RDW. bus_rvalid in the same cycle as gnt is legal: capture it and go to DONE.
- RDW: on bus_rvalid, capture the extracted/extended bus_rdata into cpu_rdata and go to DONE.
- DONE: exactly one cycle with stall low; the pipeline advances on this edge. Then go to IDLE. A request present in the next IDLE cycle is new.
- Minimum latency: store 2 stall cycles, load 2 stall cycles (gnt and rvalid together), plus bus wait cycles.
- Store lanes:
  - byte: be = 0001 << a[1:0], data byte replicated ×4.
  - half: be = 0011 << {a[1],0}, data half replicated ×2.
  - word: be = 1111.
- Load extract: select byte/half by a[1:0]. Sign-extend for 011/001, zero-extend for 100/010, pass-through for word. Unknown dmtype behaves as word.
- cpu_rdata holds its value until the next load completes; stores do not change it.
- Timeout: the counter increments each cycle in REQ/RDW. At TIMEOUT_CYC, set bus_err (sticky until reset), drop bus_req, force cpu_rdata=0 on loads, and go to DONE.
- rst low mid-transaction: immediate return to IDLE with bus_req=0. A late bus_rvalid arriving in IDLE is ignored.

Optional Feature:
- DM_MISALIGN_TRAP_EN defined:
  - Misaligned accesses (half with a[0]=1, word with a[1:0]!=0) are not issued.
  - IDLE goes straight to DONE, and cpu_misalign=1 during that DONE cycle.
  - Loads return cpu_rdata=0; stores are dropped.
- Undefined:
  - Offending low address bits are ignored (half uses {a[1],0}, word uses 00) and the access is issued normally.
  - cpu_misalign is tied 0.

Decomposition:
- Shared package: DMType encoding constants (matching the core's control encoding) and the state encoding IDLE/REQ/RDW/DONE.
- Sub-module dm_lane (combinational):
  - Store direction: addr/dmtype/wdata → be/placed wdata.
  - Load direction: addr/dmtype/rdata → extended result.
  - Instantiated once in each direction.

Test Plan:
- Store byte 0xA5 at 0x103, gnt after 2 cycles → bus_addr=0x100, be=1000, wdata=0xA5A5A5A5. cpu_stall high 3 cycles, then DONE.
- Bus word at 0x200 = 0x8001_F0FF:
  - lb 0x200 → 0xFFFFFFFF.
  - lbu 0x201 → 0x000000F0.
  - lh 0x202 → 0xFFFF8001.
  - lhu 0x202 → 0x00008001.
- Load with gnt and rvalid in the same cycle → stall exactly 2 cycles, cpu_rdata valid in DONE. Back-to-back lw then sw both issue; neither is duplicated.
- Timeout: never assert bus_gnt → after 1023 cycles bus_err=1, bus_req=0, cpu_rdata=0, stall releases.
- rst low while in RDW → bus_req=0 immediately. A later rvalid leaves cpu_rdata=0.
- With DM_MISALIGN_TRAP_EN, lw at 0x102 → no bus_req, 1-cycle stall, cpu_misalign pulse. Without it → bus_addr=0x100, be=1111.
